// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing-mode description for the multi-mode VGA timing generator.
//   vga_mode_t  : per-axis active/front-porch/sync/back-porch lengths plus
//                 sync polarity (1 = active-high pin, 0 = active-low pin).
//   MODE_TABLE  : built-in modes, entry 0 = 800x600, entry 1 = 640x480.
//   h_total / v_total : line and frame lengths derived from a mode entry.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int FIELD_W    = 16;
    localparam int MODE_COUNT = 2;

    typedef struct packed {
        logic [FIELD_W-1:0] h_active;
        logic [FIELD_W-1:0] h_fp;
        logic [FIELD_W-1:0] h_sync;
        logic [FIELD_W-1:0] h_bp;
        logic [FIELD_W-1:0] v_active;
        logic [FIELD_W-1:0] v_fp;
        logic [FIELD_W-1:0] v_sync;
        logic [FIELD_W-1:0] v_bp;
        logic               hsync_pol;
        logic               vsync_pol;
    } vga_mode_t;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam vga_mode_t MODE_800X600 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    // 640x480 @ 60 Hz, negative syncs
    localparam vga_mode_t MODE_640X480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    localparam vga_mode_t [MODE_COUNT-1:0] MODE_TABLE = {MODE_640X480, MODE_800X600};

    function automatic logic [31:0] h_total(input vga_mode_t m);
        return 32'(m.h_active) + 32'(m.h_fp) + 32'(m.h_sync) + 32'(m.h_bp);
    endfunction

    function automatic logic [31:0] v_total(input vga_mode_t m);
        return 32'(m.v_active) + 32'(m.v_fp) + 32'(m.v_sync) + 32'(m.v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One axis (horizontal or vertical) of the timing generator: a wrapping
// position counter with registered blanking and sync decode.
// The decode is taken from the value the counter is about to hold, so the
// registered blnk/sync always describe the registered count (no skew).
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : advance the counter this edge
//   total      : axis length of the mode currently running (wrap point)
//   active, fp, sync_len, pol : decode fields of the mode that will be
//                running after this edge (differs only at a frame boundary)
//   count, blnk, sync : registered position, blanking, sync pin level
//   wrap       : combinational, counter wraps to 0 on this edge
//   blnk_d     : combinational, blanking value for the next registered count
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int   CNT_W    = 11,
    parameter logic RST_SYNC = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic [31:0]      total,
    input  logic [31:0]      active,
    input  logic [31:0]      fp,
    input  logic [31:0]      sync_len,
    input  logic             pol,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             wrap,
    output logic             blnk_d
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_d_s;
    logic [31:0]      count_wide_s;
    logic [31:0]      sync_start_s;
    logic [31:0]      sync_end_s;
    logic             last_s;
    logic             sync_log_s;
    logic             sync_d_s;
    logic             blnk_d_s;
    logic             blnk_r;
    logic             sync_r;

    // Wrap detection depends only on the running mode's total, which keeps it
    // free of the next-mode selection that it feeds.
    assign last_s = ({{(32-CNT_W){1'b0}}, count_r} == (total - 32'd1));
    assign wrap   = adv & last_s;

    // Next count and its blanking/sync decode
    always_comb begin
        count_d_s = count_r;
        if (adv) begin
            if (last_s) begin
                count_d_s = {CNT_W{1'b0}};
            end else begin
                count_d_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d_s = count_r;
        end
        count_wide_s = {{(32-CNT_W){1'b0}}, count_d_s};
        sync_start_s = active + fp;
        sync_end_s   = sync_start_s + sync_len;
        blnk_d_s     = (count_wide_s >= active);
        sync_log_s   = (count_wide_s >= sync_start_s) && (count_wide_s < sync_end_s);
        if (pol) begin
            sync_d_s = sync_log_s;
        end else begin
            sync_d_s = ~sync_log_s;
        end
    end

    // Position counter and registered decode, held while not advancing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            blnk_r  <= 1'b0;
            sync_r  <= RST_SYNC;
        end else if (adv) begin
            count_r <= count_d_s;
            blnk_r  <= blnk_d_s;
            sync_r  <= sync_d_s;
        end
    end

    assign count  = count_r;
    assign blnk   = blnk_r;
    assign sync   = sync_r;
    assign blnk_d = blnk_d_s;

endmodule

// File: rtl/vga_timing_multi.sv
// -----------------------------------------------------------------------------
// vga_timing_multi
// Multi-mode VGA timing generator. The running mode is chosen from MODE_TAB
// and may only change at a frame boundary.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   ce           : pixel enable; everything holds while low
//   mode_sel     : requested mode, sampled on the last pixel of a frame;
//                  values >= NUM_MODES are ignored
//   hcount/vcount: registered pixel/line position
//   hsync/vsync  : sync pins at the running mode's polarity
//   hblnk/vblnk  : active-high blanking;  de : active video
//   line_start / frame_start : one-ce-cycle markers at (0,*) / (0,0)
//   mode_active  : mode currently driving the timing
// All outputs are registered on the same edge as the counters.
// -----------------------------------------------------------------------------
module vga_timing_multi
    import vga_pkg::*;
#(
    parameter int                        CNT_W     = 11,
    parameter int                        NUM_MODES = 2,
    parameter vga_mode_t [NUM_MODES-1:0] MODE_TAB  = MODE_TABLE[NUM_MODES-1:0],
    localparam int                       MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [MODE_W-1:0] mode_sel,
    output logic [CNT_W-1:0]  hcount,
    output logic [CNT_W-1:0]  vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              hblnk,
    output logic              vblnk,
    output logic              de,
    output logic              line_start,
    output logic              frame_start,
    output logic [MODE_W-1:0] mode_active
);

    // Every table entry must fit the counter range
    for (genvar i = 0; i < NUM_MODES; i++) begin : g_mode_chk
        if (h_total(MODE_TAB[i]) > (32'd1 << CNT_W)) begin : g_h_err
            $fatal(1, "vga_timing_multi: mode %0d H_TOTAL exceeds 2**CNT_W", i);
        end
        if (v_total(MODE_TAB[i]) > (32'd1 << CNT_W)) begin : g_v_err
            $fatal(1, "vga_timing_multi: mode %0d V_TOTAL exceeds 2**CNT_W", i);
        end
    end

    logic [MODE_W-1:0] mode_r;
    logic [MODE_W-1:0] mode_nxt_s;
    logic              sel_ok_s;
    logic [31:0]       h_total_s;
    logic [31:0]       v_total_s;
    logic              h_wrap_s;
    logic              v_wrap_s;
    logic              v_adv_s;
    logic              h_blnk_d_s;
    logic              v_blnk_d_s;
    logic              line_start_r;
    logic              frame_start_r;
    logic              de_r;

    // Wrap points always come from the mode currently running
    assign h_total_s = h_total(MODE_TAB[mode_r]);
    assign v_total_s = v_total(MODE_TAB[mode_r]);
    assign v_adv_s   = h_wrap_s;

    // Mode to run after this edge: a valid request is accepted only on the
    // ce edge that wraps both counters, so the new mode starts exactly at (0,0)
    always_comb begin
        sel_ok_s = ({{(32-MODE_W){1'b0}}, mode_sel} < 32'(NUM_MODES));
        if (ce && h_wrap_s && v_wrap_s && sel_ok_s) begin
            mode_nxt_s = mode_sel;
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    vga_axis_counter #(
        .CNT_W    (CNT_W),
        .RST_SYNC (~MODE_TAB[0].hsync_pol)
    ) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (ce),
        .total    (h_total_s),
        .active   (32'(MODE_TAB[mode_nxt_s].h_active)),
        .fp       (32'(MODE_TAB[mode_nxt_s].h_fp)),
        .sync_len (32'(MODE_TAB[mode_nxt_s].h_sync)),
        .pol      (MODE_TAB[mode_nxt_s].hsync_pol),
        .count    (hcount),
        .blnk     (hblnk),
        .sync     (hsync),
        .wrap     (h_wrap_s),
        .blnk_d   (h_blnk_d_s)
    );

    vga_axis_counter #(
        .CNT_W    (CNT_W),
        .RST_SYNC (~MODE_TAB[0].vsync_pol)
    ) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (v_adv_s),
        .total    (v_total_s),
        .active   (32'(MODE_TAB[mode_nxt_s].v_active)),
        .fp       (32'(MODE_TAB[mode_nxt_s].v_fp)),
        .sync_len (32'(MODE_TAB[mode_nxt_s].v_sync)),
        .pol      (MODE_TAB[mode_nxt_s].vsync_pol),
        .count    (vcount),
        .blnk     (vblnk),
        .sync     (vsync),
        .wrap     (v_wrap_s),
        .blnk_d   (v_blnk_d_s)
    );

    // Running mode, position markers and data enable; all hold while ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r        <= {MODE_W{1'b0}};
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            de_r          <= 1'b1;
        end else if (ce) begin
            mode_r        <= mode_nxt_s;
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
            de_r          <= ~h_blnk_d_s & ~v_blnk_d_s;
        end
    end

    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign de          = de_r;
    assign mode_active = mode_r;

endmodule

// File: tb/tb_vga_timing_multi.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_multi
// dut_a runs the built-in 800x600/640x480 table for line-level behaviour;
// dut_b runs a small three-mode table so whole frames and mode switches fit
// in a short run. Both are compared every cycle against a position-index
// reference model.
// -----------------------------------------------------------------------------
module tb_vga_timing_multi;
    import vga_pkg::*;

    localparam vga_mode_t TA0 = '{h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
                                  v_active: 16'd600, v_fp: 16'd1, v_sync: 16'd4, v_bp: 16'd23,
                                  hsync_pol: 1'b1, vsync_pol: 1'b1};
    localparam vga_mode_t TA1 = '{h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
                                  v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2, v_bp: 16'd33,
                                  hsync_pol: 1'b0, vsync_pol: 1'b0};
    localparam vga_mode_t [1:0] TA_TAB = {TA1, TA0};

    localparam vga_mode_t TB0 = '{h_active: 16'd10, h_fp: 16'd2, h_sync: 16'd3, h_bp: 16'd2,
                                  v_active: 16'd6, v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd1,
                                  hsync_pol: 1'b1, vsync_pol: 1'b1};
    localparam vga_mode_t TB1 = '{h_active: 16'd8, h_fp: 16'd1, h_sync: 16'd2, h_bp: 16'd3,
                                  v_active: 16'd5, v_fp: 16'd2, v_sync: 16'd1, v_bp: 16'd2,
                                  hsync_pol: 1'b0, vsync_pol: 1'b0};
    localparam vga_mode_t TB2 = '{h_active: 16'd12, h_fp: 16'd3, h_sync: 16'd1, h_bp: 16'd2,
                                  v_active: 16'd4, v_fp: 16'd1, v_sync: 16'd1, v_bp: 16'd1,
                                  hsync_pol: 1'b1, vsync_pol: 1'b0};
    localparam vga_mode_t [2:0] TB_TAB = {TB2, TB1, TB0};

    logic        clk = 1'b0;
    logic        rst_a, ce_a, rst_b, ce_b;
    logic [0:0]  sel_a;
    logic [1:0]  sel_b;
    logic [10:0] hcount_a, vcount_a;
    logic [7:0]  hcount_b, vcount_b;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, ls_a, fs_a;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b, de_b, ls_b, fs_b;
    logic [0:0]  ma_a;
    logic [1:0]  ma_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit b_run  = 1'b0;

    // reference model state: linear pixel index inside the frame, running mode
    int   pos_m  [2];
    int   mode_m [2];
    logic ls_m   [2];
    logic fs_m   [2];

    always #5 clk = ~clk;

    vga_timing_multi dut_a (
        .clk(clk), .rst_n(rst_a), .ce(ce_a), .mode_sel(sel_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .hblnk(hblnk_a), .vblnk(vblnk_a), .de(de_a), .line_start(ls_a),
        .frame_start(fs_a), .mode_active(ma_a)
    );

    vga_timing_multi #(.CNT_W(8), .NUM_MODES(3), .MODE_TAB(TB_TAB)) dut_b (
        .clk(clk), .rst_n(rst_b), .ce(ce_b), .mode_sel(sel_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblnk(hblnk_b), .vblnk(vblnk_b), .de(de_b), .line_start(ls_b),
        .frame_start(fs_b), .mode_active(ma_b)
    );

    function automatic vga_mode_t get_mode(int id, int m);
        if (id == 0) return TA_TAB[m];
        return TB_TAB[m];
    endfunction

    function automatic int htot(vga_mode_t m);
        return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
    endfunction

    function automatic int vtot(vga_mode_t m);
        return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
    endfunction

    function automatic logic sync_lvl(int c, int a, int f, int s, logic pol);
        logic on;
        on = (c >= a + f) && (c < a + f + s);
        return on ? pol : ~pol;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset(int id);
        pos_m[id]  = 0;
        mode_m[id] = 0;
        ls_m[id]   = 1'b0;
        fs_m[id]   = 1'b0;
    endtask

    task automatic model_edge(int id, logic rst, logic ce, int sel);
        vga_mode_t m;
        int ht, vt;
        if (!rst) begin
            model_reset(id);
        end else if (ce) begin
            m  = get_mode(id, mode_m[id]);
            ht = htot(m);
            vt = vtot(m);
            ls_m[id] = ((pos_m[id] % ht) == ht - 1);
            fs_m[id] = (pos_m[id] == ht * vt - 1);
            if (fs_m[id]) begin
                pos_m[id] = 0;
                if (sel < ((id == 0) ? 2 : 3)) mode_m[id] = sel;
            end else begin
                pos_m[id]++;
            end
        end
    endtask

    task automatic check_dut(int id, logic [31:0] hc, logic [31:0] vc, logic hs, logic vs,
                             logic hb, logic vb, logic d, logic ls, logic fs, logic [31:0] ma);
        vga_mode_t m;
        int h, v;
        string p;
        p = (id == 0) ? "A" : "B";
        m = get_mode(id, mode_m[id]);
        h = pos_m[id] % htot(m);
        v = pos_m[id] / htot(m);
        chk({p, " hcount"}, hc, h);
        chk({p, " vcount"}, vc, v);
        chk({p, " hblnk"}, 32'(hb), 32'(h >= int'(m.h_active)));
        chk({p, " vblnk"}, 32'(vb), 32'(v >= int'(m.v_active)));
        chk({p, " de"}, 32'(d), 32'((h < int'(m.h_active)) && (v < int'(m.v_active))));
        chk({p, " hsync"}, 32'(hs), 32'(sync_lvl(h, m.h_active, m.h_fp, m.h_sync, m.hsync_pol)));
        chk({p, " vsync"}, 32'(vs), 32'(sync_lvl(v, m.v_active, m.v_fp, m.v_sync, m.vsync_pol)));
        chk({p, " line_start"}, 32'(ls), 32'(ls_m[id]));
        chk({p, " frame_start"}, 32'(fs), 32'(fs_m[id]));
        chk({p, " mode_active"}, ma, mode_m[id]);
    endtask

    task automatic check_a();
        check_dut(0, 32'(hcount_a), 32'(vcount_a), hsync_a, vsync_a, hblnk_a, vblnk_a,
                  de_a, ls_a, fs_a, 32'(ma_a));
    endtask

    task automatic check_b();
        check_dut(1, 32'(hcount_b), 32'(vcount_b), hsync_b, vsync_b, hblnk_b, vblnk_b,
                  de_b, ls_b, fs_b, 32'(ma_b));
    endtask

    // one clock: randomise dut_b inputs, advance both models on the edge, compare after it
    task automatic step();
        if (b_run) begin
            ce_b  = ($urandom_range(0, 3) != 0);
            rst_b = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 39) == 0) sel_b = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        cyc++;
        model_edge(0, rst_a, ce_a, int'(sel_a));
        model_edge(1, rst_b, ce_b, int'(sel_b));
        #1;
        check_a();
        check_b();
    endtask

    initial begin
        int   nls, nrise, last_rise, per;
        logic prev;
        bit   found;

        model_reset(0);
        model_reset(1);
        rst_a = 1'b0; ce_a = 1'b1; sel_a = 1'b0;
        rst_b = 1'b0; ce_b = 1'b1; sel_b = 2'd0;

        // reset values
        repeat (3) step();
        rst_a = 1'b1;
        rst_b = 1'b1;
        b_run = 1'b1;

        // first ce edge after release: hcount 1, no marker
        step();
        chk("A first count after reset", 32'(hcount_a), 32'd1);
        chk("A no marker after reset", 32'(ls_a), 32'd0);

        // mode 0, ce always high: three line wraps in 3173 edges
        nls = 0;
        for (int i = 1; i < 3 * 1056 + 5; i++) begin
            step();
            if (ls_a) nls++;
        end
        chk("A line_start count", nls, 32'd3);

        // ce toggling: counts held two clocks, line period 2112 clocks;
        // mode_sel=1 mid-frame must not switch the mode
        sel_a     = 1'b1;
        nrise     = 0;
        last_rise = -1;
        per       = 0;
        prev      = ls_a;
        for (int i = 0; i < 4 * 2112; i++) begin
            ce_a = (i % 2 == 0);
            step();
            if (ls_a && !prev) begin
                if (last_rise >= 0) per = cyc - last_rise;
                last_rise = cyc;
                nrise++;
            end
            prev = ls_a;
        end
        chk("A line period clk", per, 32'd2112);
        chk("A line_start rises", nrise, 32'd4);
        chk("A mode kept mid-frame", 32'(ma_a), 32'd0);

        // asynchronous reset mid-line at hcount 500
        ce_a  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            if (hcount_a == 11'd500) found = 1'b1;
        end
        chk("A reached hcount 500", 32'(found), 32'd1);
        #1;
        rst_a = 1'b0;
        #1;
        model_reset(0);
        check_a();
        chk("A async reset hcount", 32'(hcount_a), 32'd0);
        repeat (3) step();
        rst_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("A count after release", 32'(hcount_a), i);
        end

        // more random frames and mode switches on dut_b
        repeat (3000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
